// File: rtl/score_arbiter.sv
// Round-robin arbiter that shares one best-score register between NUM_CORES
// hash cores; lower scores are better and only strictly-better results commit.
module score_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int SCORE_W   = 10,
  parameter int TAG_W     = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_CORES-1:0]         req_i,
  input  logic [NUM_CORES*SCORE_W-1:0] score_i,
  input  logic [NUM_CORES*TAG_W-1:0]   tag_i,
  input  logic                         clear_i,
  output logic [NUM_CORES-1:0]         ack_o,
  output logic [SCORE_W-1:0]           best_score_o,
  output logic [TAG_W-1:0]             best_tag_o,
  output logic                         best_valid_o,
  output logic                         new_best_o,
  output logic                         busy_o
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COMPARE = 1'b1
  } state_t;

  state_t               state_r;
  state_t               state_next_s;
  logic [IDX_W-1:0]     rr_ptr_r;
  logic [IDX_W-1:0]     rr_ptr_next_s;
  logic [IDX_W-1:0]     sel_s;
  logic                 grant_s;
  logic                 update_s;

  logic [IDX_W-1:0]     staged_sel_r;
  logic [SCORE_W-1:0]   staged_score_r;
  logic [TAG_W-1:0]     staged_tag_r;
  logic [IDX_W-1:0]     staged_sel_next_s;
  logic [SCORE_W-1:0]   staged_score_next_s;
  logic [TAG_W-1:0]     staged_tag_next_s;

  logic [NUM_CORES-1:0] ack_r;
  logic [NUM_CORES-1:0] ack_next_s;
  logic [SCORE_W-1:0]   best_score_r;
  logic [SCORE_W-1:0]   best_score_next_s;
  logic [TAG_W-1:0]     best_tag_r;
  logic [TAG_W-1:0]     best_tag_next_s;
  logic                 best_valid_r;
  logic                 best_valid_next_s;
  logic                 new_best_r;
  logic                 new_best_next_s;

  logic [SCORE_W-1:0]   score_arr_s [NUM_CORES];
  logic [TAG_W-1:0]     tag_arr_s   [NUM_CORES];

  // First requester at or above ptr, wrapping at NUM_CORES.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [NUM_CORES-1:0] req,
    input logic [IDX_W-1:0]     ptr
  );
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_CORES) begin
        idx = idx - NUM_CORES;
      end else begin
        idx = idx;
      end
      cand = idx[IDX_W-1:0];
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  function automatic logic [IDX_W-1:0] rr_advance(input logic [IDX_W-1:0] sel);
    logic [IDX_W-1:0] nxt;
    if (sel == IDX_W'(NUM_CORES - 1)) begin
      nxt = '0;
    end else begin
      nxt = sel + IDX_W'(1);
    end
    return nxt;
  endfunction

  function automatic logic [NUM_CORES-1:0] to_onehot(input logic [IDX_W-1:0] sel);
    logic [NUM_CORES-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_unpack
    assign score_arr_s[k] = score_i[k*SCORE_W +: SCORE_W];
    assign tag_arr_s[k]   = tag_i[k*TAG_W +: TAG_W];
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: a grant always takes exactly one COMPARE cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (|req_i) begin
          state_next_s = COMPARE;
        end else begin
          state_next_s = IDLE;
        end
      end
      COMPARE: state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Output/datapath next values; clear overrides a pending update.
  always_comb begin
    grant_s             = 1'b0;
    update_s            = 1'b0;
    sel_s               = rr_pick(req_i, rr_ptr_r);
    rr_ptr_next_s       = rr_ptr_r;
    staged_sel_next_s   = staged_sel_r;
    staged_score_next_s = staged_score_r;
    staged_tag_next_s   = staged_tag_r;
    ack_next_s          = '0;
    best_score_next_s   = best_score_r;
    best_tag_next_s     = best_tag_r;
    best_valid_next_s   = best_valid_r;
    new_best_next_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (|req_i) begin
          grant_s             = 1'b1;
          rr_ptr_next_s       = rr_advance(sel_s);
          staged_sel_next_s   = sel_s;
          staged_score_next_s = score_arr_s[sel_s];
          staged_tag_next_s   = tag_arr_s[sel_s];
          ack_next_s          = to_onehot(sel_s);
        end else begin
          grant_s = 1'b0;
        end
      end
      COMPARE: begin
        update_s = (staged_score_r < best_score_r) || !best_valid_r;
      end
      default: begin
        update_s = 1'b0;
      end
    endcase
    if (clear_i) begin
      best_score_next_s = '1;
      best_tag_next_s   = '0;
      best_valid_next_s = 1'b0;
      new_best_next_s   = 1'b0;
    end else if (update_s) begin
      best_score_next_s = staged_score_r;
      best_tag_next_s   = staged_tag_r;
      best_valid_next_s = 1'b1;
      new_best_next_s   = 1'b1;
    end else begin
      new_best_next_s = 1'b0;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_r       <= '0;
      staged_sel_r   <= '0;
      staged_score_r <= '0;
      staged_tag_r   <= '0;
      ack_r          <= '0;
      best_score_r   <= '1;
      best_tag_r     <= '0;
      best_valid_r   <= 1'b0;
      new_best_r     <= 1'b0;
    end else begin
      rr_ptr_r       <= rr_ptr_next_s;
      staged_sel_r   <= staged_sel_next_s;
      staged_score_r <= staged_score_next_s;
      staged_tag_r   <= staged_tag_next_s;
      ack_r          <= ack_next_s;
      best_score_r   <= best_score_next_s;
      best_tag_r     <= best_tag_next_s;
      best_valid_r   <= best_valid_next_s;
      new_best_r     <= new_best_next_s;
    end
  end

  assign ack_o        = ack_r;
  assign best_score_o = best_score_r;
  assign best_tag_o   = best_tag_r;
  assign best_valid_o = best_valid_r;
  assign new_best_o   = new_best_r;
  assign busy_o       = (state_r != IDLE);

endmodule

// File: tb/tb_score_arbiter.sv
// Directed bench for score_arbiter: hand-computed expectations checked with
// immediate assertions one cycle-step at a time.
module tb_score_arbiter;

  localparam int NC = 4;
  localparam int SW = 10;
  localparam int TW = 32;

  logic             clk_i;
  logic             rst_i;
  logic [NC-1:0]    req_i;
  logic [NC*SW-1:0] score_i;
  logic [NC*TW-1:0] tag_i;
  logic             clear_i;
  logic [NC-1:0]    ack_o;
  logic [SW-1:0]    best_score_o;
  logic [TW-1:0]    best_tag_o;
  logic             best_valid_o;
  logic             new_best_o;
  logic             busy_o;

  logic [SW-1:0] sc [NC];
  logic [TW-1:0] tg [NC];

  int total;
  int passed;
  int failed;

  for (genvar k = 0; k < NC; k++) begin : g_pack
    assign score_i[k*SW +: SW] = sc[k];
    assign tag_i[k*TW +: TW]   = tg[k];
  end

  score_arbiter #(.NUM_CORES(NC), .SCORE_W(SW), .TAG_W(TW)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .score_i      (score_i),
    .tag_i        (tag_i),
    .clear_i      (clear_i),
    .ack_o        (ack_o),
    .best_score_o (best_score_o),
    .best_tag_o   (best_tag_o),
    .best_valid_o (best_valid_o),
    .new_best_o   (new_best_o),
    .busy_o       (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic check_best(input string name, input logic [SW-1:0] s, input logic [TW-1:0] t,
                            input logic v, input logic nb);
    check({name, ".score"}, 64'(best_score_o), 64'(s));
    check({name, ".tag"},   64'(best_tag_o),   64'(t));
    check({name, ".valid"}, 64'(best_valid_o), 64'(v));
    check({name, ".new"},   64'(new_best_o),   64'(nb));
  endtask

  logic [SW-1:0] exp_best [5];
  logic [TW-1:0] exp_tag  [5];
  logic          exp_nb   [5];

  initial begin
    total = 0; passed = 0; failed = 0;
    rst_i = 1'b1; clear_i = 1'b0; req_i = '0;
    for (int k = 0; k < NC; k++) begin
      sc[k] = '0;
      tg[k] = '0;
    end
    tick(); tick();
    rst_i = 1'b0;

    // 1: reset state
    check_best("reset", 10'd1023, 32'h0, 1'b0, 1'b0);
    check("reset.ack",  64'(ack_o),  64'h0);
    check("reset.busy", 64'(busy_o), 64'h0);
    tick();
    check("idle.busy", 64'(busy_o), 64'h0);

    // 2: single request from core 2
    sc[2] = 10'd500; tg[2] = 32'hDEADBEEF; req_i = 4'b0100;
    tick();
    check("t2.ack",  64'(ack_o),  64'h4);
    check("t2.busy", 64'(busy_o), 64'h1);
    check("t2.nb0",  64'(new_best_o), 64'h0);
    tick();
    req_i = 4'b0000;
    check("t2.ack_clr", 64'(ack_o), 64'h0);
    check_best("t2.commit", 10'd500, 32'hDEADBEEF, 1'b1, 1'b1);
    tick();
    check("t2.nb_pulse", 64'(new_best_o), 64'h0);
    check("t2.hold", 64'(best_score_o), 64'd500);

    // 3: all cores continuous after reset
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    sc[0] = 10'd400; sc[1] = 10'd300; sc[2] = 10'd300; sc[3] = 10'd350;
    for (int k = 0; k < NC; k++) tg[k] = 32'hC0DE0000 + 32'(k);
    exp_best[0] = 10'd400; exp_tag[0] = 32'hC0DE0000; exp_nb[0] = 1'b1;
    exp_best[1] = 10'd300; exp_tag[1] = 32'hC0DE0001; exp_nb[1] = 1'b1;
    exp_best[2] = 10'd300; exp_tag[2] = 32'hC0DE0001; exp_nb[2] = 1'b0;
    exp_best[3] = 10'd300; exp_tag[3] = 32'hC0DE0001; exp_nb[3] = 1'b0;
    exp_best[4] = 10'd300; exp_tag[4] = 32'hC0DE0001; exp_nb[4] = 1'b0;
    req_i = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      check($sformatf("t3.ack%0d", g), 64'(ack_o), 64'(4'b0001 << (g % NC)));
      tick();
      if (g == 4) req_i = 4'b0000;
      check($sformatf("t3.gap%0d", g), 64'(ack_o), 64'h0);
      check_best($sformatf("t3.best%0d", g), exp_best[g], exp_tag[g], 1'b1, exp_nb[g]);
    end

    // 4: core 3 submits 301, then 0, then 0 again
    sc[3] = 10'd301; tg[3] = 32'h33; req_i = 4'b1000;
    tick();
    check("t4.ack301", 64'(ack_o), 64'h8);
    tick();
    check_best("t4.301", 10'd300, 32'hC0DE0001, 1'b1, 1'b0);
    sc[3] = 10'd0; tg[3] = 32'h30;
    tick();
    check("t4.ack0", 64'(ack_o), 64'h8);
    tick();
    check_best("t4.zero", 10'd0, 32'h30, 1'b1, 1'b1);
    tg[3] = 32'h31;
    tick();
    check("t4.ack0b", 64'(ack_o), 64'h8);
    tick();
    req_i = 4'b0000;
    check_best("t4.zero_again", 10'd0, 32'h30, 1'b1, 1'b0);

    // 5: clear in IDLE, then clear during COMPARE of score 100
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    check_best("t5.idle_clear", 10'd1023, 32'h0, 1'b0, 1'b0);
    sc[0] = 10'd300; tg[0] = 32'h5300; req_i = 4'b0001;
    tick();
    check("t5.ack300", 64'(ack_o), 64'h1);
    tick();
    check_best("t5.300", 10'd300, 32'h5300, 1'b1, 1'b1);
    sc[1] = 10'd100; tg[1] = 32'h5100; req_i = 4'b0010;
    tick();
    check("t5.ack100", 64'(ack_o), 64'h2);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0; req_i = 4'b0000;
    check_best("t5.clear_wins", 10'd1023, 32'h0, 1'b0, 1'b0);
    check("t5.ack_done", 64'(ack_o), 64'h0);

    // 6: reset during COMPARE, then cores 1 and 3 request (pointer must be 0)
    sc[1] = 10'd55; tg[1] = 32'h6055; req_i = 4'b0010;
    tick();
    check("t6.ack_pre", 64'(ack_o), 64'h2);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0; req_i = 4'b0000;
    check("t6.ack_rst",  64'(ack_o),  64'h0);
    check("t6.busy_rst", 64'(busy_o), 64'h0);
    check_best("t6.rst", 10'd1023, 32'h0, 1'b0, 1'b0);
    sc[1] = 10'd77; tg[1] = 32'h6077; sc[3] = 10'd88; tg[3] = 32'h6088;
    req_i = 4'b1010;
    tick();
    check("t6.ack_post", 64'(ack_o), 64'h2);
    tick();
    req_i = 4'b1000;
    check_best("t6.commit", 10'd77, 32'h6077, 1'b1, 1'b1);
    tick();
    check("t6.ack_next", 64'(ack_o), 64'h8);
    tick();
    req_i = 4'b0000;
    check_best("t6.worse", 10'd77, 32'h6077, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
